// File: rtl/stream_pattern_generator.sv
// AXI-Stream frame generator: after a start delay, emits Num_Frames frames of
// incrementing words 1..Frame_Length separated by idle gaps, then reports Done.
//
// state | meaning
// IDLE  | waiting for start after reset
// DELAY | counting start delay cycles
// SEND  | presenting words on the stream
// GAP   | idle cycles between frames
// DONE  | run complete, waiting for a new start
module stream_pattern_generator #(
  parameter logic [31:0] Frame_Length      = 32'd216,
  parameter logic [19:0] Start_Delay_Value = 20'd20000,
  parameter logic [7:0]  Gap_Value         = 8'd16,
  parameter logic [3:0]  Num_Frames        = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        input_r_TREADY_0,
  output logic        input_r_TVALID_0,
  output logic        input_r_TLAST_0,
  output logic [31:0] input_r_TDATA_0,
  output logic [3:0]  Frame_Counter,
  output logic        Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  // A zero delay or gap setting still spends one cycle in that state.
  localparam logic [19:0] DELAY_LAST = (Start_Delay_Value == 20'd0) ? 20'd0 : Start_Delay_Value - 20'd1;
  localparam logic [7:0]  GAP_LAST   = (Gap_Value == 8'd0) ? 8'd0 : Gap_Value - 8'd1;
  localparam logic        FIRST_LAST = (Frame_Length == 32'd1);

  state_t      state, state_n;
  logic [19:0] delay_cnt, delay_cnt_n;
  logic [7:0]  gap_cnt, gap_cnt_n;
  logic        tvalid, tvalid_n;
  logic        tlast, tlast_n;
  logic [31:0] tdata, tdata_n;
  logic [3:0]  frame_cnt, frame_cnt_n;
  logic        done, done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      delay_cnt <= 20'd0;
      gap_cnt   <= 8'd0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      tdata     <= 32'd0;
      frame_cnt <= 4'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      delay_cnt <= delay_cnt_n;
      gap_cnt   <= gap_cnt_n;
      tvalid    <= tvalid_n;
      tlast     <= tlast_n;
      tdata     <= tdata_n;
      frame_cnt <= frame_cnt_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    delay_cnt_n = delay_cnt;
    gap_cnt_n   = gap_cnt;
    tvalid_n    = tvalid;
    tlast_n     = tlast;
    tdata_n     = tdata;
    frame_cnt_n = frame_cnt;
    done_n      = done;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n     = S_DELAY;
          delay_cnt_n = 20'd0;
          frame_cnt_n = 4'd0;
          done_n      = 1'b0;
        end
      end
      S_DELAY: begin
        if (delay_cnt == DELAY_LAST) begin
          state_n  = S_SEND;
          tvalid_n = 1'b1;
          tdata_n  = 32'd1;
          tlast_n  = FIRST_LAST;
        end else begin
          delay_cnt_n = delay_cnt + 20'd1;
        end
      end
      S_SEND: begin
        // Outputs only move on a completed handshake, so a stall holds them.
        if (tvalid && input_r_TREADY_0) begin
          if (tlast) begin
            tvalid_n    = 1'b0;
            tlast_n     = 1'b0;
            tdata_n     = 32'd0;
            frame_cnt_n = frame_cnt + 4'd1;
            gap_cnt_n   = 8'd0;
            if (frame_cnt + 4'd1 == Num_Frames) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end else begin
              state_n = S_GAP;
            end
          end else begin
            tdata_n = tdata + 32'd1;
            tlast_n = (tdata + 32'd1 == Frame_Length);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n  = S_SEND;
          tvalid_n = 1'b1;
          tdata_n  = 32'd1;
          tlast_n  = FIRST_LAST;
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign input_r_TVALID_0 = tvalid;
  assign input_r_TLAST_0  = tlast;
  assign input_r_TDATA_0  = tdata;
  assign Frame_Counter    = frame_cnt;
  assign Done             = done;

endmodule

// File: tb/tb_stream_pattern_generator.sv
// Self-checking bench for stream_pattern_generator: three parameterisations
// checked cycle by cycle against a word/frame/gap sequence model.
`timescale 1ns/1ps
module tb_stream_pattern_generator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        st  [3];
  logic        rdy [3];
  logic        tv  [3];
  logic        tl  [3];
  logic [31:0] td  [3];
  logic [3:0]  fcv [3];
  logic        dn  [3];

  stream_pattern_generator #(
    .Frame_Length(32'd216), .Start_Delay_Value(20'd20), .Gap_Value(8'd16), .Num_Frames(4'd1)
  ) u_a (
    .clk(clk), .reset(reset), .start(st[0]), .input_r_TREADY_0(rdy[0]),
    .input_r_TVALID_0(tv[0]), .input_r_TLAST_0(tl[0]), .input_r_TDATA_0(td[0]),
    .Frame_Counter(fcv[0]), .Done(dn[0])
  );

  stream_pattern_generator #(
    .Frame_Length(32'd216), .Start_Delay_Value(20'd20), .Gap_Value(8'd16), .Num_Frames(4'd3)
  ) u_b (
    .clk(clk), .reset(reset), .start(st[1]), .input_r_TREADY_0(rdy[1]),
    .input_r_TVALID_0(tv[1]), .input_r_TLAST_0(tl[1]), .input_r_TDATA_0(td[1]),
    .Frame_Counter(fcv[1]), .Done(dn[1])
  );

  stream_pattern_generator #(
    .Frame_Length(32'd1), .Start_Delay_Value(20'd0), .Gap_Value(8'd0), .Num_Frames(4'd2)
  ) u_c (
    .clk(clk), .reset(reset), .start(st[2]), .input_r_TREADY_0(rdy[2]),
    .input_r_TVALID_0(tv[2]), .input_r_TLAST_0(tl[2]), .input_r_TDATA_0(td[2]),
    .Frame_Counter(fcv[2]), .Done(dn[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full run on instance d; the model tracks the next expected word,
  // completed frames and gap length, sampling every falling edge.
  // rmode: 0 ready tied high, 1 toggling, 2 random. noise: random start pulses.
  task automatic run_frames(input int d, input int fl, input int sdv, input int gap,
                            input int nf, input int rmode, input bit noise);
    int sdv_e, gap_e, w, f, gcnt, k, budget;
    bit seen_valid, finished, gap_pending;
    logic v, l;
    logic [31:0] dd;
    sdv_e = (sdv == 0) ? 1 : sdv;
    gap_e = (gap == 0) ? 1 : gap;
    w = 1; f = 0; gcnt = 0; k = 1;
    seen_valid = 0; finished = 0; gap_pending = 0;
    budget = sdv_e + nf * (fl * 8 + gap_e + 4) + 40;
    @(negedge clk); st[d] = 1'b1; rdy[d] = 1'b0;
    @(negedge clk); st[d] = 1'b0;
    while (!finished && k <= budget) begin
      v = tv[d]; l = tl[d]; dd = td[d];
      chk("frame_counter", fcv[d], f);
      chk("done_low", dn[d], 0);
      if (!seen_valid) begin
        if (k < sdv_e + 1) chk("delay_valid_low", v, 0);
        else begin
          chk("valid_rise", v, 1);
          seen_valid = 1;
        end
      end
      if (!v) begin
        chk("idle_data", dd, 0);
        chk("idle_last", l, 0);
        if (gap_pending) gcnt++;
      end else begin
        if (gap_pending) begin
          chk("gap_len", gcnt, gap_e);
          gap_pending = 0;
        end
        chk("data", dd, w);
        chk("last", l, (w == fl));
      end
      rdy[d] = (rmode == 0) ? 1'b1 : (rmode == 1) ? k[0] : 1'($urandom_range(0, 1));
      if (noise) st[d] = 1'($urandom_range(0, 1));
      if (v && rdy[d]) begin
        if (w == fl) begin
          f++;
          w = 1;
          if (f == nf) finished = 1;
          else begin
            gap_pending = 1;
            gcnt = 0;
          end
        end else begin
          w++;
        end
      end
      @(negedge clk);
      k++;
    end
    st[d] = 1'b0;
    chk("run_budget", finished, 1);
    chk("done_high", dn[d], 1);
    chk("final_count", fcv[d], nf);
    chk("done_valid_low", tv[d], 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      rdy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", tv[i], 0);
      chk("rst_last", tl[i], 0);
      chk("rst_data", td[i], 0);
      chk("rst_count", fcv[i], 0);
      chk("rst_done", dn[i], 0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", tv[0], 0);

    run_frames(0, 216, 20, 16, 1, 0, 0);
    run_frames(0, 216, 20, 16, 1, 1, 0);
    run_frames(1, 216, 20, 16, 3, 0, 0);
    run_frames(1, 216, 20, 16, 3, 2, 0);
    run_frames(2, 1, 0, 0, 2, 2, 1);
    run_frames(2, 1, 0, 0, 2, 2, 1);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk); st[0] = 1'b1; rdy[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    n = 0;
    while (td[0] != 32'd100 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_100", td[0], 100);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", tv[0], 0);
    chk("async_data", td[0], 0);
    chk("async_last", tl[0], 0);
    chk("async_count", fcv[0], 0);
    chk("async_done", dn[0], 0);
    @(negedge clk); reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_valid", tv[0], 0);
      chk("post_rst_done", dn[0], 0);
    end
    run_frames(0, 216, 20, 16, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_pattern_generator.md
STREAM_PATTERN_GENERATOR -- requirements
Module: stream_pattern_generator

Interface
REQ-001 SHALL have parameter Frame_Length, default 32'd216: words per frame; legal range 1..2^32-1.
REQ-002 SHALL have parameter Start_Delay_Value, default 20'd20000: clock cycles spent in DELAY after start.
REQ-003 SHALL have parameter Gap_Value, default 8'd16: idle cycles between consecutive frames.
REQ-004 SHALL have parameter Num_Frames, default 4'd1: frames per run; legal range 1..15.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: run request, sampled only in IDLE and DONE.
REQ-008 SHALL have port input_r_TREADY_0, input, 1: AXI-Stream ready from the downstream matrix multiplier.
REQ-009 SHALL have port input_r_TVALID_0, output, 1: AXI-Stream valid.
REQ-010 SHALL have port input_r_TLAST_0, output, 1: high on the final word of each frame.
REQ-011 SHALL have port input_r_TDATA_0, output, 32: stream payload.
REQ-012 SHALL have port Frame_Counter, output, 4: number of frames fully transferred in the current run.
REQ-013 SHALL have port Done, output, 1: high while in DONE.

Function
REQ-014 SHALL implement FSM states IDLE, DELAY, SEND, GAP, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> DELAY next cycle, with the delay counter cleared to 0 and Frame_Counter cleared to 0.
REQ-016 DELAY: delay counter increments every cycle; at count == Start_Delay_Value-1 -> SEND next cycle; Start_Delay_Value=0 SHALL behave as 1.
REQ-017 SEND entry: TVALID=1, TDATA=32'd1, TLAST = (Frame_Length==1).
REQ-018 Beat transfers only on a cycle with TVALID=1 and TREADY=1; TVALID, TDATA and TLAST SHALL remain stable while TVALID=1 and TREADY=0.
REQ-019 TVALID SHALL NOT depend combinationally on TREADY, and SHALL NOT drop without a transfer.
REQ-020 Non-last transfer: TDATA increments by 1 next cycle; TLAST=1 exactly when TDATA==Frame_Length.
REQ-021 Last transfer (TLAST=1): next cycle TVALID=0, TLAST=0, TDATA=0, and Frame_Counter increments by 1.
REQ-022 After a last transfer, if the new Frame_Counter == Num_Frames -> DONE, else -> GAP.
REQ-023 GAP SHALL hold TVALID=0 for exactly Gap_Value cycles (0 treated as 1), then -> SEND, restarting TDATA at 1.
REQ-024 DONE: Done=1 and Frame_Counter holds; start=1 -> DELAY exactly as from IDLE, with Done=0 from the next cycle.
REQ-025 start SHALL be ignored in DELAY, SEND and GAP; there is no abort input.
REQ-026 TDATA SHALL be 32'd0 whenever TVALID=0.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force state IDLE, TVALID=0, TLAST=0, TDATA=0, Frame_Counter=0, Done=0, and clear all internal counters.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release the block stays in IDLE until start.

Verification
REQ-029 Frame_Length=216, Start_Delay_Value=20, Num_Frames=1, TREADY tied 1, one-cycle start -> TVALID rises 21 cycles after start; TDATA runs 1..216 on consecutive cycles; TLAST on 216 only; Frame_Counter=1; Done=1.
REQ-030 Same setup with TREADY toggling 1/0 every cycle -> all 216 words delivered exactly once and in order, held stable while stalled, TLAST on 216.
REQ-031 Num_Frames=3, Gap_Value=16 -> three frames of 1..216 separated by exactly 16 TVALID=0 cycles; Frame_Counter steps 1,2,3; Done=1 after the third TLAST transfer.
REQ-032 Assert reset asynchronously (off clock edge) while TDATA=100 -> TVALID=0 immediately; after release no output activity until start; a new start sends TDATA 1..216.
REQ-033 Frame_Length=1 -> a single beat with TDATA=1 and TLAST=1 per frame; start pulses during DELAY or SEND have no effect; start in DONE begins a new run with Frame_Counter reset to 0.
